// File: rtl/mem_access_ctrl_if.sv
// Bundle of loader/dumper, core-array and IRAM/DRAM signals around mem_access_ctrl.
// Latency: none; wires only.
// Backpressure: none here; cores hold core_req until granted, the ext side is never stalled.
interface mem_access_ctrl_if #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 9
);
   logic [2:0]                  mode;
   logic [ADDR_W-1:0]           ext_addr;
   logic [DATA_W-1:0]           ext_wdata;
   logic                        ext_we;
   logic                        ext_re;
   logic [DATA_W-1:0]           ext_rdata;
   logic                        ext_rvalid;
   logic [NUM_CORES-1:0]        core_req;
   logic [NUM_CORES-1:0]        core_we;
   logic [NUM_CORES*ADDR_W-1:0] core_addr;
   logic [NUM_CORES*DATA_W-1:0] core_wdata;
   logic [NUM_CORES-1:0]        core_gnt;
   logic [NUM_CORES-1:0]        core_rvalid;
   logic [DATA_W-1:0]           core_rdata;
   logic                        iram_we;
   logic [ADDR_W-1:0]           iram_addr;
   logic [DATA_W-1:0]           iram_wdata;
   logic                        dram_we;
   logic                        dram_re;
   logic [ADDR_W-1:0]           dram_addr;
   logic [DATA_W-1:0]           dram_wdata;
   logic [DATA_W-1:0]           dram_rdata;
   logic                        busy;
   logic                        err_mode;

   // Surroundings: mode source, loader/dumper, core array and the memories.
   modport master (
      output mode, ext_addr, ext_wdata, ext_we, ext_re,
      output core_req, core_we, core_addr, core_wdata, dram_rdata,
      input  ext_rdata, ext_rvalid, core_gnt, core_rvalid, core_rdata,
      input  iram_we, iram_addr, iram_wdata,
      input  dram_we, dram_re, dram_addr, dram_wdata, busy, err_mode
   );

   // The controller itself.
   modport slave (
      input  mode, ext_addr, ext_wdata, ext_we, ext_re,
      input  core_req, core_we, core_addr, core_wdata, dram_rdata,
      output ext_rdata, ext_rvalid, core_gnt, core_rvalid, core_rdata,
      output iram_we, iram_addr, iram_wdata,
      output dram_we, dram_re, dram_addr, dram_wdata, busy, err_mode
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Mode FSM plus round-robin DRAM arbiter sharing IRAM/DRAM between the loader/dumper and the cores.
// Latency: strobes 1 cycle after the sampling edge; read data/valid 2 cycles after the request edge.
// Backpressure: cores hold core_req until core_gnt; the ext side is never stalled; mode switches wait out an in-flight read.
module mem_access_ctrl #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 9
) (
   input logic              clock,
   input logic              reset,
   mem_access_ctrl_if.slave bus
);
   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP, S_DRAIN
   } state_t;

   state_t            state, state_nx, target;
   logic              mode_bad;
   logic              stay;
   logic              win_vld;
   logic [PW-1:0]     win_idx;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     ptr_nx;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              issue_rd;

   // The single outstanding read: who gets the return pulse.
   logic              rd_pend;
   logic              rd_core;
   logic [PW-1:0]     rd_tag;

   logic [DATA_W-1:0]    ext_rdata_q;
   logic                 ext_rvalid_q;
   logic [NUM_CORES-1:0] core_gnt_q;
   logic [NUM_CORES-1:0] core_rvalid_q;
   logic [DATA_W-1:0]    core_rdata_q;
   logic                 iram_we_q;
   logic [ADDR_W-1:0]    iram_addr_q;
   logic [DATA_W-1:0]    iram_wdata_q;
   logic                 dram_we_q;
   logic                 dram_re_q;
   logic [ADDR_W-1:0]    dram_addr_q;
   logic [DATA_W-1:0]    dram_wdata_q;
   logic                 busy_q;
   logic                 err_mode_q;

   // Decode the requested mode; illegal encodings fall back to IDLE and are flagged.
   always_comb begin
      target   = S_IDLE;
      mode_bad = 1'b0;
      case (bus.mode)
         3'd0:    target = S_IDLE;
         3'd1:    target = S_LOAD_I;
         3'd2:    target = S_LOAD_D;
         3'd3:    target = S_RUN;
         3'd4:    target = S_DUMP;
         default: mode_bad = 1'b1;
      endcase
   end

   // Next state: switch directly unless a read is still due back, then park in DRAIN for its return.
   always_comb begin
      state_nx = state;
      if (state == S_DRAIN) begin
         if (!rd_pend) state_nx = target;
      end else if (target != state) begin
         state_nx = rd_pend ? S_DRAIN : target;
      end
   end

   // New grants and reads are only issued on edges where the mode is not changing.
   assign stay = (target == state);

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_CORES.
   always_comb begin : p_arb
      int j;
      j       = 0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NUM_CORES) j = j - NUM_CORES;
         if (!win_vld && bus.core_req[j]) begin
            win_vld = 1'b1;
            win_idx = PW'(j);
         end
      end
   end

   assign ptr_nx    = (int'(win_idx) == NUM_CORES - 1) ? '0 : win_idx + 1'b1;
   assign win_we    = bus.core_we[win_idx];
   assign win_addr  = bus.core_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign win_wdata = bus.core_wdata[int'(win_idx)*DATA_W +: DATA_W];
   assign issue_rd  = stay && (((state == S_DUMP) && bus.ext_re) ||
                               ((state == S_RUN) && win_vld && !win_we));

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Registered strobes, grants, read returns and status; strobes default to a single-cycle pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr        <= '0;
         rd_pend       <= 1'b0;
         rd_core       <= 1'b0;
         rd_tag        <= '0;
         ext_rdata_q   <= '0;
         ext_rvalid_q  <= 1'b0;
         core_gnt_q    <= '0;
         core_rvalid_q <= '0;
         core_rdata_q  <= '0;
         iram_we_q     <= 1'b0;
         iram_addr_q   <= '0;
         iram_wdata_q  <= '0;
         dram_we_q     <= 1'b0;
         dram_re_q     <= 1'b0;
         dram_addr_q   <= '0;
         dram_wdata_q  <= '0;
         busy_q        <= 1'b0;
         err_mode_q    <= 1'b0;
      end else begin
         err_mode_q    <= err_mode_q | mode_bad;
         busy_q        <= (state_nx == S_DRAIN) || issue_rd;
         ext_rvalid_q  <= 1'b0;
         core_gnt_q    <= '0;
         core_rvalid_q <= '0;
         iram_we_q     <= 1'b0;
         dram_we_q     <= 1'b0;
         dram_re_q     <= 1'b0;
         rd_pend       <= 1'b0;

         // Return of the read issued last cycle, routed by its tag whatever the state is now.
         if (rd_pend) begin
            if (rd_core) begin
               core_rvalid_q[rd_tag] <= 1'b1;
               core_rdata_q          <= bus.dram_rdata;
            end else begin
               ext_rvalid_q <= 1'b1;
               ext_rdata_q  <= bus.dram_rdata;
            end
         end

         case (state)
            S_LOAD_I: begin
               if (bus.ext_we) begin
                  iram_we_q    <= 1'b1;
                  iram_addr_q  <= bus.ext_addr;
                  iram_wdata_q <= bus.ext_wdata;
               end
            end
            S_LOAD_D: begin
               if (bus.ext_we) begin
                  dram_we_q    <= 1'b1;
                  dram_addr_q  <= bus.ext_addr;
                  dram_wdata_q <= bus.ext_wdata;
               end
            end
            S_DUMP: begin
               if (stay && bus.ext_re) begin
                  dram_re_q   <= 1'b1;
                  dram_addr_q <= bus.ext_addr;
                  rd_pend     <= 1'b1;
                  rd_core     <= 1'b0;
               end
            end
            S_RUN: begin
               if (stay && win_vld) begin
                  core_gnt_q[win_idx] <= 1'b1;
                  dram_addr_q         <= win_addr;
                  rr_ptr              <= ptr_nx;
                  if (win_we) begin
                     dram_we_q    <= 1'b1;
                     dram_wdata_q <= win_wdata;
                  end else begin
                     dram_re_q <= 1'b1;
                     rd_pend   <= 1'b1;
                     rd_core   <= 1'b1;
                     rd_tag    <= win_idx;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ext_rdata   = ext_rdata_q;
   assign bus.ext_rvalid  = ext_rvalid_q;
   assign bus.core_gnt    = core_gnt_q;
   assign bus.core_rvalid = core_rvalid_q;
   assign bus.core_rdata  = core_rdata_q;
   assign bus.iram_we     = iram_we_q;
   assign bus.iram_addr   = iram_addr_q;
   assign bus.iram_wdata  = iram_wdata_q;
   assign bus.dram_we     = dram_we_q;
   assign bus.dram_re     = dram_re_q;
   assign bus.dram_addr   = dram_addr_q;
   assign bus.dram_wdata  = dram_wdata_q;
   assign bus.busy        = busy_q;
   assign bus.err_mode    = err_mode_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized RUN and DUMP traffic.
// Latency: expects strobes one cycle and read returns two cycles after the sampling edge.
// Backpressure: models cores holding req until granted and dropping it for the grant cycle.
module tb_mem_access_ctrl;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 9;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   m_ptr  = 0;   // model round-robin pointer

   mem_access_ctrl_if #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

   mem_access_ctrl #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [95:0] all_outs();
      return {bus.ext_rdata, bus.ext_rvalid, bus.core_gnt, bus.core_rvalid, bus.core_rdata,
              bus.iram_we, bus.iram_addr, bus.iram_wdata, bus.dram_we, bus.dram_re,
              bus.dram_addr, bus.dram_wdata, bus.busy, bus.err_mode};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.mode       = 3'd0;
      bus.ext_addr   = '0;
      bus.ext_wdata  = '0;
      bus.ext_we     = 1'b0;
      bus.ext_re     = 1'b0;
      bus.core_req   = '0;
      bus.core_we    = '0;
      bus.core_addr  = '0;
      bus.core_wdata = '0;
      bus.dram_rdata = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs %h, want 0", all_outs());
         end
      end
      reset = 1'b0;
      step();
      checks++;
      if (all_outs() !== '0) begin
         errors++;
         $display("FAIL reset_release_idle: outputs %h, want 0", all_outs());
      end
   endtask

   task automatic test_load();
      bus.mode = 3'd1;
      step();
      checks++;
      if (bus.iram_we !== 1'b0) begin
         errors++;
         $display("FAIL load_i_entry: iram_we %b, want 0", bus.iram_we);
      end
      for (int k = 0; k < 4; k++) begin
         bus.ext_we    = 1'b1;
         bus.ext_addr  = AW'(k);
         bus.ext_wdata = DW'(16'h1000 + k);
         step();
         checks++;
         if ({bus.iram_we, bus.iram_addr, bus.iram_wdata, bus.dram_we} !==
             {1'b1, AW'(k), DW'(16'h1000 + k), 1'b0}) begin
            errors++;
            $display("FAIL load_i_write%0d: we=%b addr=%h data=%h dram_we=%b, want 1 %h %h 0",
                     k, bus.iram_we, bus.iram_addr, bus.iram_wdata, bus.dram_we, k, 16'h1000 + k);
         end
      end
      bus.ext_we = 1'b0;
      step();
      checks++;
      if (bus.iram_we !== 1'b0) begin
         errors++;
         $display("FAIL load_i_end: iram_we %b, want 0", bus.iram_we);
      end

      bus.mode = 3'd2;
      step();
      for (int k = 0; k < 4; k++) begin
         bus.ext_we    = 1'b1;
         bus.ext_addr  = AW'(k);
         bus.ext_wdata = DW'(16'h1000 + k);
         step();
         checks++;
         if ({bus.dram_we, bus.dram_addr, bus.dram_wdata, bus.iram_we} !==
             {1'b1, AW'(k), DW'(16'h1000 + k), 1'b0}) begin
            errors++;
            $display("FAIL load_d_write%0d: we=%b addr=%h data=%h iram_we=%b, want 1 %h %h 0",
                     k, bus.dram_we, bus.dram_addr, bus.dram_wdata, bus.iram_we, k, 16'h1000 + k);
         end
      end
      // Random write bursts with gaps.
      for (int k = 0; k < 12; k++) begin
         logic          we;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         we = 1'($urandom_range(0, 1));
         a  = AW'($urandom);
         d  = DW'($urandom);
         bus.ext_we    = we;
         bus.ext_addr  = a;
         bus.ext_wdata = d;
         step();
         checks++;
         if (we ? ({bus.dram_we, bus.dram_addr, bus.dram_wdata} !== {1'b1, a, d})
                : (bus.dram_we !== 1'b0)) begin
            errors++;
            $display("FAIL load_d_rand%0d: we=%b addr=%h data=%h, want we=%b addr=%h data=%h",
                     k, bus.dram_we, bus.dram_addr, bus.dram_wdata, we, a, d);
         end
      end
      bus.ext_we = 1'b0;
      bus.mode   = 3'd0;
      step();
   endtask

   task automatic test_round_robin();
      int last;
      int exp_w;
      bus.mode = 3'd3;
      step();
      for (int c = 0; c < N; c++) begin
         bus.core_addr[c*AW +: AW]  = AW'(9'h10 + c);
         bus.core_wdata[c*DW +: DW] = DW'(16'h0111 * c);
      end
      bus.core_we = '1;
      last = -1;
      for (int g = 0; g < 5; g++) begin
         logic [N-1:0] eg;
         bus.core_req = '1;
         if (last >= 0) bus.core_req[last] = 1'b0;
         step();
         exp_w = g % N;
         eg = '0;
         eg[exp_w] = 1'b1;
         checks++;
         if ({bus.core_gnt, bus.dram_we, bus.dram_addr} !== {eg, 1'b1, AW'(9'h10 + exp_w)}) begin
            errors++;
            $display("FAIL rr_grant%0d: gnt=%b we=%b addr=%h, want gnt=%b we=1 addr=%h",
                     g, bus.core_gnt, bus.dram_we, bus.dram_addr, eg, 9'h10 + exp_w);
         end
         last  = exp_w;
         m_ptr = (exp_w + 1) % N;
      end
      bus.core_req = '0;
      step();
      checks++;
      if ({bus.core_gnt, bus.dram_we, bus.dram_re} !== '0) begin
         errors++;
         $display("FAIL rr_no_req: gnt=%b we=%b re=%b, want all 0",
                  bus.core_gnt, bus.dram_we, bus.dram_re);
      end
   endtask

   task automatic test_run_random();
      logic          pend  [N];
      logic          p_we  [N];
      logic [AW-1:0] p_addr[N];
      logic [DW-1:0] p_wd  [N];
      logic [DW-1:0] rdv;
      logic [N-1:0]  eg;
      logic [N-1:0]  ev;
      int            prev_rd;
      int            last_gnt;
      int            exp_w;
      for (int c = 0; c < N; c++) pend[c] = 1'b0;
      prev_rd  = -1;
      last_gnt = -1;
      for (int cyc = 0; cyc < 41; cyc++) begin
         for (int c = 0; c < N; c++) begin
            if (cyc < 40 && !pend[c] && c != last_gnt && $urandom_range(0, 1) == 1) begin
               pend[c]   = 1'b1;
               p_we[c]   = 1'($urandom_range(0, 1));
               p_addr[c] = AW'($urandom);
               p_wd[c]   = DW'($urandom);
            end
            bus.core_req[c]            = pend[c];
            bus.core_we[c]             = p_we[c];
            bus.core_addr[c*AW +: AW]  = p_addr[c];
            bus.core_wdata[c*DW +: DW] = p_wd[c];
         end
         rdv = DW'($urandom);
         bus.dram_rdata = rdv;
         exp_w = -1;
         for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (exp_w < 0 && pend[j]) exp_w = j;
         end
         step();
         eg = '0;
         if (exp_w >= 0) eg[exp_w] = 1'b1;
         checks++;
         if (bus.core_gnt !== eg) begin
            errors++;
            $display("FAIL run_gnt%0d: gnt=%b, want %b", cyc, bus.core_gnt, eg);
         end
         checks++;
         if (exp_w >= 0) begin
            if ({bus.dram_we, bus.dram_re, bus.dram_addr} !== {p_we[exp_w], !p_we[exp_w], p_addr[exp_w]} ||
                (p_we[exp_w] && bus.dram_wdata !== p_wd[exp_w])) begin
               errors++;
               $display("FAIL run_mem%0d: we=%b re=%b addr=%h wd=%h, want we=%b addr=%h wd=%h",
                        cyc, bus.dram_we, bus.dram_re, bus.dram_addr, bus.dram_wdata,
                        p_we[exp_w], p_addr[exp_w], p_wd[exp_w]);
            end
         end else if ({bus.dram_we, bus.dram_re} !== 2'b00) begin
            errors++;
            $display("FAIL run_idle%0d: we=%b re=%b, want 0 0", cyc, bus.dram_we, bus.dram_re);
         end
         ev = '0;
         if (prev_rd >= 0) ev[prev_rd] = 1'b1;
         checks++;
         if (bus.core_rvalid !== ev || (prev_rd >= 0 && bus.core_rdata !== rdv)) begin
            errors++;
            $display("FAIL run_rvalid%0d: rvalid=%b rdata=%h, want %b %h",
                     cyc, bus.core_rvalid, bus.core_rdata, ev, rdv);
         end
         prev_rd = (exp_w >= 0 && !p_we[exp_w]) ? exp_w : -1;
         if (exp_w >= 0) begin
            pend[exp_w] = 1'b0;
            m_ptr       = (exp_w + 1) % N;
         end
         last_gnt = exp_w;
      end
      bus.core_req = '0;
      step();
   endtask

   task automatic test_read_return();
      bus.core_req              = 4'b0100;
      bus.core_we               = '0;
      bus.core_addr[2*AW +: AW] = 9'h005;
      bus.dram_rdata            = 16'hBEEF;
      step();
      checks++;
      if ({bus.core_gnt, bus.dram_re, bus.dram_we, bus.dram_addr} !== {4'b0100, 1'b1, 1'b0, 9'h005}) begin
         errors++;
         $display("FAIL rd_grant: gnt=%b re=%b we=%b addr=%h, want 0100 1 0 005",
                  bus.core_gnt, bus.dram_re, bus.dram_we, bus.dram_addr);
      end
      bus.core_req = '0;
      step();
      checks++;
      if ({bus.core_rvalid, bus.core_rdata, bus.core_gnt} !== {4'b0100, 16'hBEEF, 4'b0000}) begin
         errors++;
         $display("FAIL rd_return: rvalid=%b rdata=%h gnt=%b, want 0100 beef 0000",
                  bus.core_rvalid, bus.core_rdata, bus.core_gnt);
      end
   endtask

   task automatic test_drain_dump();
      logic          re_prev;
      logic          re;
      logic [AW-1:0] a;
      logic [DW-1:0] rdv;
      bus.core_req              = 4'b0010;
      bus.core_we               = '0;
      bus.core_addr[1*AW +: AW] = 9'h007;
      bus.dram_rdata            = 16'h1234;
      step();
      checks++;
      if (bus.core_gnt !== 4'b0010) begin
         errors++;
         $display("FAIL drain_grant: gnt=%b, want 0010", bus.core_gnt);
      end
      bus.core_req = '0;
      bus.mode     = 3'd4;
      step();
      checks++;
      if ({bus.core_rvalid, bus.core_rdata, bus.busy} !== {4'b0010, 16'h1234, 1'b1}) begin
         errors++;
         $display("FAIL drain_return: rvalid=%b rdata=%h busy=%b, want 0010 1234 1",
                  bus.core_rvalid, bus.core_rdata, bus.busy);
      end
      step();
      checks++;
      if ({bus.busy, bus.core_rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL drain_done: busy=%b rvalid=%b, want 0 0000", bus.busy, bus.core_rvalid);
      end
      // DUMP: ext_we and core requests must be ignored.
      bus.ext_re   = 1'b1;
      bus.ext_addr = 9'h005;
      bus.ext_we   = 1'b1;
      bus.core_req = '1;
      step();
      checks++;
      if ({bus.dram_re, bus.dram_addr, bus.dram_we, bus.core_gnt, bus.ext_rvalid} !==
          {1'b1, 9'h005, 1'b0, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL dump_issue: re=%b addr=%h we=%b gnt=%b rvalid=%b, want 1 005 0 0000 0",
                  bus.dram_re, bus.dram_addr, bus.dram_we, bus.core_gnt, bus.ext_rvalid);
      end
      bus.ext_re     = 1'b0;
      bus.ext_we     = 1'b0;
      bus.core_req   = '0;
      bus.dram_rdata = 16'hCAFE;
      step();
      checks++;
      if ({bus.ext_rvalid, bus.ext_rdata} !== {1'b1, 16'hCAFE}) begin
         errors++;
         $display("FAIL dump_return: rvalid=%b rdata=%h, want 1 cafe", bus.ext_rvalid, bus.ext_rdata);
      end
      // Pipelined random reads, one per cycle when requested.
      re_prev = 1'b0;
      for (int k = 0; k < 17; k++) begin
         re  = (k < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
         a   = AW'($urandom);
         rdv = DW'($urandom);
         bus.ext_re     = re;
         bus.ext_addr   = a;
         bus.dram_rdata = rdv;
         step();
         checks++;
         if (bus.dram_re !== re || (re && bus.dram_addr !== a) ||
             bus.ext_rvalid !== re_prev || (re_prev && bus.ext_rdata !== rdv)) begin
            errors++;
            $display("FAIL dump_pipe%0d: re=%b addr=%h rvalid=%b rdata=%h, want re=%b addr=%h rvalid=%b rdata=%h",
                     k, bus.dram_re, bus.dram_addr, bus.ext_rvalid, bus.ext_rdata, re, a, re_prev, rdv);
         end
         re_prev = re;
      end
      bus.ext_re = 1'b0;
   endtask

   task automatic test_illegal_mode();
      bus.mode     = 3'd6;
      bus.ext_we   = 1'b1;
      bus.ext_re   = 1'b1;
      bus.core_req = '1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if ({bus.err_mode, bus.iram_we, bus.dram_we, bus.dram_re, bus.core_gnt} !== {1'b1, 7'b0}) begin
            errors++;
            $display("FAIL illegal%0d: err=%b iram_we=%b dram_we=%b dram_re=%b gnt=%b, want 1 0 0 0 0000",
                     k, bus.err_mode, bus.iram_we, bus.dram_we, bus.dram_re, bus.core_gnt);
         end
      end
      bus.mode      = 3'd1;
      bus.ext_re    = 1'b0;
      bus.core_req  = '0;
      bus.ext_addr  = 9'h003;
      bus.ext_wdata = 16'h55AA;
      step();
      checks++;
      if ({bus.err_mode, bus.iram_we} !== 2'b10) begin
         errors++;
         $display("FAIL illegal_switch: err=%b iram_we=%b, want 1 0", bus.err_mode, bus.iram_we);
      end
      step();
      checks++;
      if ({bus.err_mode, bus.iram_we, bus.iram_addr, bus.iram_wdata} !== {2'b11, 9'h003, 16'h55AA}) begin
         errors++;
         $display("FAIL illegal_sticky: err=%b iram_we=%b addr=%h data=%h, want 1 1 003 55aa",
                  bus.err_mode, bus.iram_we, bus.iram_addr, bus.iram_wdata);
      end
      bus.ext_we = 1'b0;
      bus.mode   = 3'd0;
      step();
   endtask

   task automatic test_reset_mid_run();
      bus.mode = 3'd3;
      step();
      bus.core_req              = 4'b0010;
      bus.core_we               = '0;
      bus.core_addr[1*AW +: AW] = 9'h009;
      bus.dram_rdata            = 16'h7777;
      step();
      checks++;
      if ({bus.core_gnt, bus.dram_re} !== {4'b0010, 1'b1}) begin
         errors++;
         $display("FAIL rst_setup: gnt=%b re=%b, want 0010 1", bus.core_gnt, bus.dram_re);
      end
      bus.core_req = '0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (all_outs() !== '0) begin
         errors++;
         $display("FAIL rst_async: outputs %h, want 0", all_outs());
      end
      step();
      reset    = 1'b0;
      bus.mode = 3'd0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if ({bus.core_rvalid, bus.err_mode, bus.busy} !== 6'b0) begin
            errors++;
            $display("FAIL rst_after%0d: rvalid=%b err=%b busy=%b, want 0000 0 0",
                     k, bus.core_rvalid, bus.err_mode, bus.busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_round_robin();
      test_run_random();
      test_read_return();
      test_drain_dump();
      test_illegal_mode();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Parametrised memory-access controller, successor to the single-core top-level memory glue.
- Multiplexes the IRAM and one shared DRAM between an external loader/dumper and NUM_CORES processor cores.
- Replaces the ad-hoc, priority-by-if-order control with an explicit mode FSM and a round-robin DRAM arbiter.
- Sits between the core array and the iram/dram instances in the multicore top level.

Parameters:
NUM_CORES, 4, number of cores contending for DRAM (1..16)
DATA_W, 16, data word width
ADDR_W, 9, IRAM/DRAM address width

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
mode  in  3  0 IDLE, 1 LOAD_I, 2 LOAD_D, 3 RUN, 4 DUMP; 5-7 illegal
ext_addr  in  ADDR_W  external load/dump address
ext_wdata  in  DATA_W  external write data
ext_we  in  1  external write strobe (LOAD_I/LOAD_D)
ext_re  in  1  external read strobe (DUMP)
ext_rdata  out  DATA_W  dump read data
ext_rvalid  out  1  dump read data valid, 1-cycle pulse
core_req  in  NUM_CORES  per-core DRAM request, held until granted
core_we  in  NUM_CORES  per-core write(1)/read(0)
core_addr  in  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
core_wdata  in  NUM_CORES*DATA_W  per-core write data, same packing
core_gnt  out  NUM_CORES  one-hot grant pulse
core_rvalid  out  NUM_CORES  one-hot read-return pulse
core_rdata  out  DATA_W  read data, shared bus
iram_we  out  1  IRAM write enable
iram_addr  out  ADDR_W  IRAM load address
iram_wdata  out  DATA_W  IRAM write data
dram_we  out  1  DRAM write enable
dram_re  out  1  DRAM read enable
dram_addr  out  ADDR_W  DRAM address
dram_wdata  out  DATA_W  DRAM write data
dram_rdata  in  DATA_W  DRAM registered read data, valid 1 cycle after dram_re
busy  out  1  transaction in flight or mode switch pending
err_mode  out  1  sticky: illegal mode seen; cleared only by reset

Behaviour:
- Reset (async): all outputs 0. FSM=IDLE. Round-robin pointer=0. In-flight tag cleared. Reset mid-transaction drops that transaction; no rvalid afterwards.
- Every output is registered.
- FSM states: IDLE, LOAD_I, LOAD_D, RUN, DUMP, DRAIN.
- Mode switching:
  - mode sampled each edge.
  - If mode differs from the current state and no read is in flight: go directly to the new state.
  - If a read is in flight: enter DRAIN. busy=1 until the return pulse, then go to the requested state.
  - Illegal mode (5-7): set err_mode; behave as IDLE.
- IDLE: no memory strobes. core_gnt=0. ext inputs ignored.
- LOAD_I: on ext_we at edge T, iram_we/iram_addr/iram_wdata driven during cycle T+1 (one-cycle pulse). Back-to-back writes are allowed every cycle.
- LOAD_D: same as LOAD_I, but on the dram_we/dram_addr/dram_wdata path.
- DUMP:
  - ext_re at edge T drives dram_re and dram_addr in cycle T+1.
  - ext_rdata=dram_rdata and ext_rvalid=1 in cycle T+2.
  - Pipelined: one read accepted per cycle.
  - ext_we is ignored.
- RUN:
  - At each edge, the arbiter selects one requesting core.
  - Search starts at the pointer and wraps modulo NUM_CORES.
  - Winner w: core_gnt[w]=1 for the next cycle. dram_* are driven from core w's fields in that same cycle.
  - Pointer becomes (w+1) mod NUM_CORES.
  - No request: pointer unchanged and no strobes.
  - Read grant: core_rvalid[w]=1 and core_rdata=dram_rdata one cycle after the grant cycle. The tag (w) is held in a pipeline register.
  - A core must deassert req in the cycle it sees gnt; a req still high then is treated as a new request.
  - ext_* are ignored.
- A core write and a pending read return may coincide; both complete because return data is tagged.
- In all non-RUN states, core_gnt and core_rvalid are 0, apart from the DRAIN return pulse.

Test Plan:
- Reset: assert reset mid-RUN with a read outstanding -> all outputs 0 immediately; no core_rvalid after release; err_mode=0.
- Load: LOAD_I, ext_we with addr 0..3 and data 0x1000..0x1003 on consecutive cycles -> iram_we high 4 cycles, each one cycle late, with matching addr/data. Repeat for LOAD_D on the dram_* outputs.
- Round-robin: RUN with NUM_CORES=4 and all core_req held (each core drops its req for 1 cycle after its grant) -> grant order 0,1,2,3,0. No core is granted twice before the others.
- Read return: core 2 reads addr 0x05 while DRAM returns 0xBEEF -> gnt[2] at T+1, core_rvalid=0b0100 and core_rdata=0xBEEF at T+2.
- Drain and dump: switch mode RUN->DUMP in the cycle after a read grant -> busy=1 for 1 cycle, core_rvalid still delivered. Then DUMP ext_re for addr 5 -> ext_rvalid with the DRAM word 2 cycles later.
- Illegal mode: drive mode=6 -> err_mode=1, no strobes. err_mode stays 1 after mode=1, until reset.
